fifo_rr_arbiter: RTL
====================

// Module: fifo_rr_arbiter
// PURPOSE
//  Downstream drain stage for four DATA_SIZE-wide FIFOs of the FIFO block family.
//  Round-robin pops non-empty input FIFOs and pushes the words into one output
//  FIFO. Throttles on the output FIFO pause (almost-full) flag.
//  Tags each pushed word with its source index.
// PARAMETERS
//  DATA_SIZE   6   width of each FIFO data word
//  CNT_SIZE    8   width of per-input statistics counters (ARB_STATS_EN only)
// PORTS
//  clk          in   1            single clock; all logic on posedge
//  reset        in   1            synchronous, active-high reset
//  enable       in   1            1 = arbitration allowed
//  fifo_empty   in   4            empty flag of input FIFO i (bit i)
//  fifo_data    in   4*DATA_SIZE  data of FIFO i at [i*DATA_SIZE +: DATA_SIZE]
//  fifo_pop     out  4            one-hot read strobe to FIFO i
//  out_pause    in   1            output FIFO almost_full; 1 = stop new pops
//  out_push     out  1            write strobe to output FIFO
//  out_data     out  DATA_SIZE    word pushed to output FIFO
//  out_src      out  2            index of the FIFO that out_data came from
//  busy         out  1            1 while any pop is in flight
//  stat_count   out  4*CNT_SIZE   pushed-word count per input (ARB_STATS_EN only)
// BEHAVIOUR
//  Reset values: fifo_pop=0, out_push=0, out_data=0, out_src=0, busy=0,
//   rr_ptr=3 (input 0 served first), state=IDLE, stat_count=0.
//  Reset is honoured mid-operation: in-flight pops are dropped, no push follows.
//  Input FIFO timing: data of FIFO i is valid in cycle N+1 after fifo_pop[i]=1
//   in cycle N (registered read).
//  Pipeline: pop in cycle N -> capture fifo_data[sel] at end of N+1.
//   out_push=1 with out_data/out_src valid in cycle N+2.
//   Latency is fixed at 2 cycles; throughput is max one word per cycle.
//  All outputs are registered; fifo_pop is at most one-hot.
//  Grant: first i in order rr_ptr+1, rr_ptr+2, ... (mod 4) that meets all of:
//   fifo_empty[i]=0, and i was not popped in the previous cycle.
//   The previous-cycle guard covers the stale empty flag after a last-word pop.
//   Result: one lone non-empty source is popped at most every other cycle.
//  rr_ptr updates to the granted index only when a pop is issued.
//  State machine:
//   IDLE : no pops. -> RUN when enable=1 and out_pause=0.
//   RUN  : one grant per cycle if any FIFO is eligible.
//          -> PAUSE when out_pause=1. -> IDLE when enable=0.
//   PAUSE: no new pops. -> RUN when out_pause=0 and enable=1.
//          -> IDLE when enable=0.
//   The new state takes effect the cycle after out_pause/enable change.
//   Pops already issued always complete their push: up to 2 words after pause.
//   The output FIFO almost-full threshold must therefore leave >=3 free entries.
//  busy = OR of the two pipeline valid bits.
//  All fifo_empty=1 in RUN: no pop, stay in RUN, rr_ptr unchanged.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   stat_count[i] increments on each out_push with out_src=i.
//   Counters saturate at all-ones; reset clears them.
//  ARB_STATS_EN undefined:
//   stat_count port and counters are absent. Other behaviour is identical.
// TESTING
//  1. Reset held 2 cycles, all FIFOs non-empty.
//     -> outputs stay at reset values; first pop after release is fifo_pop=4'b0001.
//  2. All 4 FIFOs hold 3 words (0x03..0x0E), enable=1.
//     -> pop order 0,1,2,3,0,1,...; out_src follows the same order 2 cycles later;
//        12 pushes total.
//  3. Only FIFO 2 non-empty with 4 words.
//     -> fifo_pop=4'b0100 on alternate cycles; 4 pushes; no pop to an empty FIFO.
//  4. out_pause rises while streaming.
//     -> at most 2 further pushes, then none; resume after pause drops;
//        no word lost or duplicated.
//  5. reset pulsed 1 cycle right after a pop.
//     -> no out_push for that pop; rr_ptr back to 3.
//  6. ARB_STATS_EN defined, scenario 2, then 300 pushes from FIFO 0.
//     -> stat_count[0] saturates at 0xFF; counts 1..3 each read 3.

Source files
------------

// File: rtl/fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_arbiter_if
//  Description : Bundles the signals between fifo_rr_arbiter and its
//                surroundings: four input FIFOs on one side and a single
//                output FIFO on the other.
//                master : seen from the arbiter (drives pops and pushes)
//                slave  : seen from the FIFO side / environment
//  Signals     : enable      1             arbitration allowed
//                fifo_empty  4             empty flag of input FIFO i
//                fifo_data   4*DATA_SIZE   read data of input FIFO i
//                fifo_pop    4             one-hot read strobe to FIFO i
//                out_pause   1             output FIFO almost-full
//                out_push    1             write strobe to output FIFO
//                out_data    DATA_SIZE     word written to output FIFO
//                out_src     2             source FIFO index of out_data
//                busy        1             a pop is in flight
//                stat_count  4*CNT_SIZE    per-input push counters
//  Options     : ARB_STATS_EN  adds CNT_SIZE and stat_count
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_rr_arbiter_if #(
  parameter int DATA_SIZE = 6
`ifdef ARB_STATS_EN
  , parameter int CNT_SIZE = 8
`endif
);
  logic                   enable;
  logic [3:0]             fifo_empty;
  logic [4*DATA_SIZE-1:0] fifo_data;
  logic [3:0]             fifo_pop;
  logic                   out_pause;
  logic                   out_push;
  logic [DATA_SIZE-1:0]   out_data;
  logic [1:0]             out_src;
  logic                   busy;
`ifdef ARB_STATS_EN
  logic [4*CNT_SIZE-1:0]  stat_count;
`endif

  modport master (
    input  enable, fifo_empty, fifo_data, out_pause,
    output fifo_pop, out_push, out_data, out_src, busy
`ifdef ARB_STATS_EN
    , output stat_count
`endif
  );

  modport slave (
    output enable, fifo_empty, fifo_data, out_pause,
    input  fifo_pop, out_push, out_data, out_src, busy
`ifdef ARB_STATS_EN
    , input stat_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_arbiter
//  Description : Drains four input FIFOs round-robin into one output FIFO.
//                A pop issued in cycle N is captured at the end of N+1 and
//                pushed (with its source index) in cycle N+2. New pops stop
//                while the output FIFO signals pause; pops already issued
//                still complete, so at most two words follow a pause.
//  Ports       : clk    single clock, posedge
//                reset  synchronous, active-high
//                bus    fifo_rr_arbiter_if.master (handshake / data bundle)
//  Options     : ARB_STATS_EN  per-input saturating push counters on
//                              bus.stat_count (width CNT_SIZE each)
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rr_arbiter #(
  parameter int DATA_SIZE = 6
`ifdef ARB_STATS_EN
  , parameter int CNT_SIZE = 8
`endif
) (
  input wire logic          clk,
  input wire logic          reset,
  fifo_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_rr_ptr;
  logic [3:0]            r_pop;       // pipeline stage 1: pop on the wire
  logic [1:0]            r_pop_idx;
  logic                  r_cap_vld;   // pipeline stage 2: data arriving
  logic [1:0]            r_cap_idx;
  logic                  r_push;
  logic [DATA_SIZE-1:0]  r_out_data;
  logic [1:0]            r_out_src;
  logic                  r_busy;

  logic [3:0]            w_eligible;
  logic [1:0]            w_cand;
  logic                  w_grant_vld;
  logic [1:0]            w_grant_idx;
  logic                  w_issue;
  logic [DATA_SIZE-1:0]  w_sel_data;

  // Round-robin search starting after the last granted index. The FIFO
  // popped this cycle is excluded: its empty flag does not yet reflect the
  // pop, so it may be stale after the last word.
  always_comb begin
    w_eligible  = ~bus.fifo_empty & ~r_pop;
    w_grant_vld = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_cand      = r_rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_rr_ptr + 2'(k);
      if (!w_grant_vld && w_eligible[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Next-state and pop-issue logic. Besides being in RUN, a pop needs the
  // live enable/pause inputs, so a rising pause stops new pops immediately
  // and bounds the trailing pushes to the two already in the pipeline.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable && !bus.out_pause) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.enable)        w_state_nxt = ST_IDLE;
        else if (bus.out_pause) w_state_nxt = ST_PAUSE;
        w_issue = bus.enable && !bus.out_pause && w_grant_vld;
      end
      ST_PAUSE: begin
        if (!bus.enable)         w_state_nxt = ST_IDLE;
        else if (!bus.out_pause) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered read on the input FIFO: data for the pop in N is on the bus
  // during N+1, selected by the index carried in stage 2.
  assign w_sel_data = bus.fifo_data[r_cap_idx*DATA_SIZE +: DATA_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= 2'd3;
      r_pop      <= 4'b0000;
      r_pop_idx  <= 2'd0;
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= 2'd0;
      r_push     <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= 2'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_issue) r_rr_ptr <= w_grant_idx;
      r_pop     <= w_issue ? (4'b0001 << w_grant_idx) : 4'b0000;
      r_pop_idx <= w_grant_idx;
      r_cap_vld <= |r_pop;
      r_cap_idx <= r_pop_idx;
      r_push    <= r_cap_vld;
      if (r_cap_vld) begin
        r_out_data <= w_sel_data;
        r_out_src  <= r_cap_idx;
      end
      // Registered OR of the next values of both stage valid bits.
      r_busy    <= w_issue | (|r_pop);
    end
  end

  assign bus.fifo_pop = r_pop;
  assign bus.out_push = r_push;
  assign bus.out_data = r_out_data;
  assign bus.out_src  = r_out_src;
  assign bus.busy     = r_busy;

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [CNT_SIZE-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (r_push && (r_out_src == 2'(gi)) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign bus.stat_count[gi*CNT_SIZE +: CNT_SIZE] = r_cnt;
  end
`endif

endmodule
`default_nettype wire
